// File: rtl/lemming_pkg.sv
// Shared types for the lemming bridge: FSM state encoding and direction
// constants used for the tie-break priority register.
package lemming_pkg;

   typedef enum logic [2:0] {
      IDLE,
      FLOW_R,
      DRAIN_R,
      FLOW_L,
      DRAIN_L
   } bridge_state_t;

   // prio holds the side that wins the next tie in IDLE
   localparam logic DIR_LEFT  = 1'b0;
   localparam logic DIR_RIGHT = 1'b1;

endpackage

// File: rtl/lemming_occ_counter.sv
// Bridge occupancy counter: +1 per grant, -1 per qualified exit.
// An exit counts only when valid is set and the bridge is not already empty.
module lemming_occ_counter #(
   parameter int CAP = 4,
   parameter int CW  = $clog2(CAP + 1)
) (
   input  logic          clk,
   input  logic          areset,
   input  logic          inc,
   input  logic          dec,
   input  logic          valid,
   output logic [CW-1:0] count,
   output logic          full,
   output logic          empty
);

   logic dec_ok;

   assign dec_ok = dec && valid && !empty;
   assign full   = (count == CW'(CAP));
   assign empty  = (count == '0);

   always_ff @(posedge clk or posedge areset) begin
      if (areset) begin
         count <= '0;
      end else if (inc && !dec_ok) begin
         count <= count + 1'b1;
      end else if (dec_ok && !inc) begin
         count <= count - 1'b1;
      end
   end

endmodule

// File: rtl/lemming_bridge_arbiter.sv
// Single-lane bridge arbiter: grants entry, tracks occupancy, drains before a
// direction change. Define LEMMING_BRIDGE_FAIRNESS_EN to enable the MAX_BURST limit.
module lemming_bridge_arbiter
   import lemming_pkg::*;
#(
   parameter int CAP       = 4,
   parameter int MAX_BURST = 8,
   parameter int CW        = $clog2(CAP + 1)
) (
   input  logic          clk,
   input  logic          areset,
   input  logic          req_l,
   input  logic          req_r,
   input  logic          exit_r,
   input  logic          exit_l,
   output logic          grant_l,
   output logic          grant_r,
   output logic          flow_right,
   output logic          flow_left,
   output logic [CW-1:0] occupancy,
   output logic          err
);

   if (CAP < 1 || MAX_BURST < 1) begin : g_bad_cfg
      $error("lemming_bridge_arbiter: CAP and MAX_BURST must be >= 1");
   end

   bridge_state_t state;
   logic          prio;
   logic          full;
   logic          empty;
   logic          switch_r;
   logic          switch_l;
   logic          exit_bad;

   assign flow_right = (state == FLOW_R) || (state == DRAIN_R);
   assign flow_left  = (state == FLOW_L) || (state == DRAIN_L);

`ifdef LEMMING_BRIDGE_FAIRNESS_EN
   localparam int BW = $clog2(MAX_BURST + 1);

   logic [BW-1:0] burst;
   logic          burst_hit;
   logic          enter_flow;

   assign burst_hit  = (burst == BW'(MAX_BURST));
   assign switch_r   = req_r && (burst_hit || !req_l);
   assign switch_l   = req_l && (burst_hit || !req_r);
   assign enter_flow = ((state == IDLE) && (req_l || req_r)) ||
                       (((state == DRAIN_R) || (state == DRAIN_L)) && empty);

   // Saturates at MAX_BURST so a late opposite request still sees the limit
   always_ff @(posedge clk or posedge areset) begin
      if (areset) begin
         burst <= '0;
      end else if (enter_flow) begin
         burst <= '0;
      end else if ((grant_l || grant_r) && !burst_hit) begin
         burst <= burst + 1'b1;
      end
   end
`else
   assign switch_r = req_r && !req_l;
   assign switch_l = req_l && !req_r;
`endif

   // Mealy grants; full is registered so a same-cycle exit cannot unblock
   assign grant_l = (state == FLOW_R) && req_l && !full && !switch_r;
   assign grant_r = (state == FLOW_L) && req_r && !full && !switch_l;

   assign exit_bad = (exit_r && !(flow_right && !empty)) ||
                     (exit_l && !(flow_left && !empty));

   lemming_occ_counter #(
      .CAP (CAP),
      .CW  (CW)
   ) u_occ (
      .clk    (clk),
      .areset (areset),
      .inc    (grant_l || grant_r),
      .dec    (flow_right ? exit_r : exit_l),
      .valid  (flow_right || flow_left),
      .count  (occupancy),
      .full   (full),
      .empty  (empty)
   );

   always_ff @(posedge clk or posedge areset) begin
      if (areset) begin
         state <= IDLE;
         prio  <= DIR_LEFT;
         err   <= 1'b0;
      end else begin
         if (exit_bad) begin
            err <= 1'b1;
         end
         case (state)
            IDLE: begin
               if (req_l && (!req_r || prio == DIR_LEFT)) begin
                  state <= FLOW_R;
                  prio  <= DIR_RIGHT;
               end else if (req_r) begin
                  state <= FLOW_L;
                  prio  <= DIR_LEFT;
               end
            end
            FLOW_R: begin
               if (switch_r) begin
                  state <= DRAIN_R;
               end else if (!req_l && !req_r && empty) begin
                  state <= IDLE;
               end
            end
            DRAIN_R: begin
               if (empty) begin
                  state <= FLOW_L;
                  prio  <= DIR_LEFT;
               end
            end
            FLOW_L: begin
               if (switch_l) begin
                  state <= DRAIN_L;
               end else if (!req_l && !req_r && empty) begin
                  state <= IDLE;
               end
            end
            DRAIN_L: begin
               if (empty) begin
                  state <= FLOW_R;
                  prio  <= DIR_RIGHT;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_lemming_bridge_arbiter.sv
// Self-checking bench for lemming_bridge_arbiter: directed scenarios plus
// randomized traffic, all compared against a behavioural bridge model.
module tb_lemming_bridge_arbiter;

   localparam int CAP       = 4;
   localparam int MAX_BURST = 2;
   localparam int CW        = $clog2(CAP + 1);

   logic          clk = 1'b0;
   logic          areset;
   logic          req_l, req_r, exit_r, exit_l;
   logic          grant_l, grant_r, flow_right, flow_left, err;
   logic [CW-1:0] occupancy;

   int checks = 0;
   int errors = 0;

   // Model: m_dir 0 = bridge unused, 1 = rightward traffic, 2 = leftward
   int m_dir, m_occ, m_run;
   bit m_drain, m_favor_left, m_err;
   bit e_gl, e_gr;

   lemming_bridge_arbiter #(
      .CAP       (CAP),
      .MAX_BURST (MAX_BURST)
   ) dut (
      .clk        (clk),
      .areset     (areset),
      .req_l      (req_l),
      .req_r      (req_r),
      .exit_r     (exit_r),
      .exit_l     (exit_l),
      .grant_l    (grant_l),
      .grant_r    (grant_r),
      .flow_right (flow_right),
      .flow_left  (flow_left),
      .occupancy  (occupancy),
      .err        (err)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
      end
   endtask

   function automatic bit must_yield(input bit other, input bit own);
`ifdef LEMMING_BRIDGE_FAIRNESS_EN
      return other && (m_run >= MAX_BURST || !own);
`else
      return other && !own;
`endif
   endfunction

   task automatic model_reset();
      m_dir = 0; m_occ = 0; m_run = 0;
      m_drain = 0; m_favor_left = 1; m_err = 0;
      e_gl = 0; e_gr = 0;
   endtask

   task automatic model_comb();
      e_gl = (m_dir == 1) && !m_drain && req_l && (m_occ < CAP) && !must_yield(req_r, req_l);
      e_gr = (m_dir == 2) && !m_drain && req_r && (m_occ < CAP) && !must_yield(req_l, req_r);
   endtask

   task automatic model_seq();
      bit good_r, good_l, own, other;
      int occ_next;
      good_r = exit_r && (m_dir == 1) && (m_occ > 0);
      good_l = exit_l && (m_dir == 2) && (m_occ > 0);
      if ((exit_r && !good_r) || (exit_l && !good_l)) m_err = 1;
      occ_next = m_occ + int'(e_gl) + int'(e_gr) - int'(good_r) - int'(good_l);
      m_run = m_run + int'(e_gl) + int'(e_gr);
      if (m_dir == 0) begin
         if (req_l && (!req_r || m_favor_left)) begin
            m_dir = 1; m_favor_left = 0; m_run = 0;
         end else if (req_r) begin
            m_dir = 2; m_favor_left = 1; m_run = 0;
         end
      end else if (!m_drain) begin
         own   = (m_dir == 1) ? req_l : req_r;
         other = (m_dir == 1) ? req_r : req_l;
         if (must_yield(other, own)) m_drain = 1;
         else if (!own && !other && m_occ == 0) m_dir = 0;
      end else if (m_occ == 0) begin
         m_dir = 3 - m_dir; m_drain = 0; m_run = 0;
         m_favor_left = (m_dir == 2);
      end
      m_occ = occ_next;
   endtask

   task automatic compare_all(input string tag);
      check({tag, ".grant_l"}, grant_l, e_gl);
      check({tag, ".grant_r"}, grant_r, e_gr);
      check({tag, ".flow_right"}, flow_right, m_dir == 1);
      check({tag, ".flow_left"}, flow_left, m_dir == 2);
      check({tag, ".occupancy"}, occupancy, m_occ);
      check({tag, ".err"}, err, m_err);
   endtask

   task automatic drive(input bit rl, input bit rr, input bit xr, input bit xl);
      req_l = rl; req_r = rr; exit_r = xr; exit_l = xl;
   endtask

   // Called at a negedge with inputs set; returns at the following negedge
   task automatic cycle(input string tag);
      #1;
      model_comb();
      compare_all(tag);
      @(posedge clk);
      model_seq();
      @(negedge clk);
   endtask

   task automatic do_reset();
      @(negedge clk);
      drive(0, 0, 0, 0);
      areset = 1'b1;
      model_reset();
      #1;
      compare_all("reset");
      @(negedge clk);
      areset = 1'b0;
   endtask

   initial begin
      int gr_cnt;
      areset = 1'b0;
      drive(0, 0, 0, 0);
      model_reset();

      // Fill to CAP, block, then resume one cycle after an exit
      do_reset();
      drive(1, 0, 0, 0);
      repeat (7) cycle("fill");
      check("fill_occ", occupancy, 4);
      drive(1, 0, 1, 0);
      #1;
      check("full_block", grant_l, 0);
      cycle("full_exit");
      drive(1, 0, 0, 0);
      #1;
      check("cap_resume", grant_l, 1);
      cycle("resume");

      // Both sides requesting continuously with exits keeping room
      do_reset();
      gr_cnt = 0;
      for (int i = 0; i < 40; i++) begin
         drive(1, 1, (m_dir == 1) && (m_occ > 0), (m_dir == 2) && (m_occ > 0));
         #1;
         gr_cnt += int'(grant_r);
         cycle("contend");
      end
`ifdef LEMMING_BRIDGE_FAIRNESS_EN
      check("fair_right_served", gr_cnt > 0, 1);
`else
      check("unfair_right_starved", gr_cnt, 0);
`endif

      // Tie-break alternation through IDLE
      do_reset();
      drive(1, 1, 0, 0);
      cycle("tie1");
      check("tie1_right", flow_right, 1);
      drive(1, 0, 0, 0);
      cycle("tie1_grant");
      drive(0, 0, 1, 0);
      cycle("tie1_exit");
      drive(0, 0, 0, 0);
      cycle("tie1_idle");
      drive(1, 1, 0, 0);
      cycle("tie2");
      check("tie2_left", flow_left, 1);

      // Protocol errors: wrong-direction exit, exit in IDLE
      do_reset();
      drive(1, 0, 0, 0);
      cycle("err_setup");
      cycle("err_grant");
      drive(0, 0, 0, 1);
      cycle("err_wrongdir");
      check("err_set", err, 1);
      check("err_occ_kept", occupancy, 1);
      drive(0, 0, 1, 0);
      cycle("err_exit");
      drive(0, 0, 0, 0);
      cycle("err_to_idle");
      drive(0, 0, 1, 0);
      cycle("err_idle_exit");
      check("err_sticky", err, 1);

      // Asynchronous reset in DRAIN_L with three lemmings aboard
      do_reset();
      drive(0, 1, 0, 0);
      repeat (4) cycle("drain_fill");
      drive(0, 0, 1, 0);
      cycle("drain_err");
      drive(1, 0, 0, 0);
      cycle("drain_enter");
      #1;
      model_comb();
      compare_all("drain_state");
      #1;
      areset = 1'b1;
      model_reset();
      #1;
      check("areset_occ", occupancy, 0);
      check("areset_flow_left", flow_left, 0);
      check("areset_grant_l", grant_l, 0);
      check("areset_grant_r", grant_r, 0);
      check("areset_err", err, 0);
      @(negedge clk);
      areset = 1'b0;
      drive(0, 0, 0, 0);

      // Randomized traffic: requesters hold until granted, mostly legal exits
      do_reset();
      for (int i = 0; i < 600; i++) begin
         if (!req_l && $urandom_range(0, 3) == 0) req_l = 1'b1;
         if (!req_r && $urandom_range(0, 3) == 0) req_r = 1'b1;
         exit_r = (m_dir == 1) && (m_occ > 0) && ($urandom_range(0, 2) == 0);
         exit_l = (m_dir == 2) && (m_occ > 0) && ($urandom_range(0, 2) == 0);
         if ($urandom_range(0, 99) == 0) exit_r = 1'b1;
         cycle("rand");
         if (e_gl) req_l = 1'b0;
         if (e_gr) req_r = 1'b0;
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
